// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
// Load path between the memory-access stage and a word-addressed memory with a
// registered read. Takes one load at a time (byte address + RISC-V funct3),
// issues a one-cycle word-aligned read strobe, waits MEM_LATENCY edges, then
// returns the byte/halfword/word with sign or zero extension over a
// valid/ready response handshake.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/LW requests skip the memory and answer
//               immediately with rsp_err=1, rsp_data=0.
//   undefined : rsp_err is tied low; misaligned offsets are truncated.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_addr[31:0]      byte address of the load
//   req_funct3[2:0]     000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others = LW)
//   mem_addr[31:0]      word-aligned byte address to memory
//   mem_rstrb           one-cycle read strobe
//   mem_rdata[31:0]     word returned by memory
//   rsp_valid/rsp_ready response handshake
//   rsp_data[31:0]      extended load result
//   rsp_err             misaligned-access flag
// -----------------------------------------------------------------------------
module load_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned CNT_W = 4;

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("load_unit: MEM_LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_mem_addr;
    logic              r_mem_rstrb;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_fmt;
    logic              w_misalign;

    // Misalignment decode of the incoming request
`ifdef MISALIGN_CHECK_EN
    logic              r_rsp_err;

    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = req_addr[0];
            default:        w_misalign = (req_addr[1:0] != 2'b00);
        endcase
    end

    assign rsp_err = r_rsp_err;
`else
    assign w_misalign = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // Lane select and extension of the returned word
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = mem_rdata;
        endcase
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_off       <= 2'd0;
            r_funct3    <= 3'd0;
            r_cnt       <= '0;
            r_mem_addr  <= 32'd0;
            r_mem_rstrb <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
`ifdef MISALIGN_CHECK_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_off    <= req_addr[1:0];
                        r_funct3 <= req_funct3;
                        if (w_misalign) begin
                            // Answer straight away; memory is never touched
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 32'd0;
`ifdef MISALIGN_CHECK_EN
                            r_rsp_err   <= 1'b1;
`endif
                            r_state     <= RESP;
                        end else begin
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_rstrb <= 1'b1;
`ifdef MISALIGN_CHECK_EN
                            r_rsp_err   <= 1'b0;
`endif
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_mem_rstrb <= 1'b0;
                    r_cnt       <= CNT_W'(MEM_LATENCY - 1);
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        // Only edge at which mem_rdata is sampled
                        r_rsp_data  <= w_fmt;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign mem_addr  = r_mem_addr;
    assign mem_rstrb = r_mem_rstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_load_unit.sv
// -----------------------------------------------------------------------------
// tb_load_unit
// Drives two load_unit instances (MEM_LATENCY 1 and 3) with identical requests,
// each attached to its own registered-read memory model. Expected results are
// queued when a request is driven and checked when each DUT hands back data.
// -----------------------------------------------------------------------------
module tb_load_unit;

`ifdef MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        rsp_ready;

    logic        a_req_ready, a_rstrb, a_valid, a_err;
    logic [31:0] a_addr, a_rdata, a_data;
    logic        b_req_ready, b_rstrb, b_valid, b_err;
    logic [31:0] b_addr, b_rdata, b_data, b_p0, b_p1;

    logic [31:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic [32:0] ea, eb;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] data;
        int          hold;
    } vec_t;

    vec_t vt[15];

    load_unit #(.MEM_LATENCY(1)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .mem_addr(a_addr), .mem_rstrb(a_rstrb), .mem_rdata(a_rdata),
        .rsp_valid(a_valid), .rsp_ready(rsp_ready),
        .rsp_data(a_data), .rsp_err(a_err)
    );

    load_unit #(.MEM_LATENCY(3)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .mem_addr(b_addr), .mem_rstrb(b_rstrb), .mem_rdata(b_rdata),
        .rsp_valid(b_valid), .rsp_ready(rsp_ready),
        .rsp_data(b_data), .rsp_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memories; garbage when not strobed so mistimed capture shows
    always @(posedge clk) begin
        a_rdata <= a_rstrb ? mem[a_addr[9:2]] : 32'hDEADBEEF;
        b_p0    <= b_rstrb ? mem[b_addr[9:2]] : 32'hDEADBEEF;
        b_p1    <= b_p0;
        b_rdata <= b_p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic is_mis(input logic [31:0] a, input logic [2:0] f);
        logic raw;
        case (f)
            3'b000, 3'b100: raw = 1'b0;
            3'b001, 3'b101: raw = a[0];
            default:        raw = (a[1:0] != 2'b00);
        endcase
        return CHECK_EN & raw;
    endfunction

    // Scoreboard checks at the negedge before the consuming edge
    always @(negedge clk) begin
        if (!reset && a_valid && rsp_ready) begin
            if (qa.size() == 0) chk("a_unexpected_rsp", 32'd1, 32'd0);
            else begin
                ea = qa.pop_front();
                chk("a_rsp_data", a_data, ea[31:0]);
                chk("a_rsp_err", 32'(a_err), 32'(ea[32]));
            end
        end
        if (!reset && b_valid && rsp_ready) begin
            if (qb.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
            else begin
                eb = qb.pop_front();
                chk("b_rsp_data", b_data, eb[31:0]);
                chk("b_rsp_err", 32'(b_err), 32'(eb[32]));
            end
        end
    end

    task automatic chk_reset_vals();
        chk("a_reset_req_ready", 32'(a_req_ready), 32'd1);
        chk("a_reset_mem_addr", a_addr, 32'd0);
        chk("a_reset_rstrb", 32'(a_rstrb), 32'd0);
        chk("a_reset_valid", 32'(a_valid), 32'd0);
        chk("a_reset_data", a_data, 32'd0);
        chk("a_reset_err", 32'(a_err), 32'd0);
        chk("b_reset_req_ready", 32'(b_req_ready), 32'd1);
        chk("b_reset_mem_addr", b_addr, 32'd0);
        chk("b_reset_rstrb", 32'(b_rstrb), 32'd0);
        chk("b_reset_valid", 32'(b_valid), 32'd0);
        chk("b_reset_data", b_data, 32'd0);
        chk("b_reset_err", 32'(b_err), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] data_nm, input int hold);
        logic        mis;
        logic [31:0] ed;
        logic [31:0] wa;
        int          na, nb, sa, sb;
        mis = is_mis(addr, f3);
        ed  = mis ? 32'd0 : data_nm;
        wa  = {addr[31:2], 2'b00};
        qa.push_back({mis, ed});
        qb.push_back({mis, ed});
        rsp_ready  = (hold == 0);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("a_req_ready_busy", 32'(a_req_ready), 32'd0);
        chk("b_req_ready_busy", 32'(b_req_ready), 32'd0);
        na = -1; nb = -1; sa = 0; sb = 0;
        for (int n = 0; n <= 40; n++) begin
            if (na < 0) begin
                if (a_rstrb) sa++;
                if (a_valid) na = n;
                else if (!mis) chk("a_mem_addr", a_addr, wa);
            end
            if (nb < 0) begin
                if (b_rstrb) sb++;
                if (b_valid) nb = n;
                else if (!mis) chk("b_mem_addr", b_addr, wa);
            end
            if (na >= 0 && nb >= 0) break;
            @(posedge clk); #1;
        end
        if (na < 0 || nb < 0) begin
            chk("rsp_timeout", 32'd1, 32'd0);
        end
        chk("a_latency", 32'(na), mis ? 32'd0 : 32'd2);
        chk("b_latency", 32'(nb), mis ? 32'd0 : 32'd4);
        chk("a_rstrb_cycles", 32'(sa), mis ? 32'd0 : 32'd1);
        chk("b_rstrb_cycles", 32'(sb), mis ? 32'd0 : 32'd1);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("a_hold_valid", 32'(a_valid), 32'd1);
                chk("b_hold_valid", 32'(b_valid), 32'd1);
                chk("a_hold_data", a_data, ed);
                chk("b_hold_data", b_data, ed);
                chk("a_hold_req_ready", 32'(a_req_ready), 32'd0);
                chk("b_hold_req_ready", 32'(b_req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("a_back_idle", 32'(a_req_ready), 32'd1);
        chk("b_back_idle", 32'(b_req_ready), 32'd1);
        chk("a_valid_dropped", 32'(a_valid), 32'd0);
        chk("b_valid_dropped", 32'(b_valid), 32'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[100] = 32'h04030201;
        mem[101] = 32'h08070605;
        mem[103] = 32'hFF0F0E0D;

        vt[0]  = '{32'd400, 3'b000, 32'h00000001, 0};
        vt[1]  = '{32'd415, 3'b000, 32'hFFFFFFFF, 0};
        vt[2]  = '{32'd415, 3'b100, 32'h000000FF, 0};
        vt[3]  = '{32'd413, 3'b000, 32'h0000000E, 0};
        vt[4]  = '{32'd414, 3'b001, 32'hFFFFFF0F, 0};
        vt[5]  = '{32'd414, 3'b101, 32'h0000FF0F, 0};
        vt[6]  = '{32'd412, 3'b101, 32'h00000E0D, 0};
        vt[7]  = '{32'd404, 3'b010, 32'h08070605, 3};
        vt[8]  = '{32'd402, 3'b010, 32'h04030201, 0};
        vt[9]  = '{32'd413, 3'b001, 32'h00000E0D, 0};
        vt[10] = '{32'd404, 3'b011, 32'h08070605, 0};
        vt[11] = '{32'd412, 3'b111, 32'hFF0F0E0D, 0};
        vt[12] = '{32'd406, 3'b000, 32'h00000007, 0};
        vt[13] = '{32'd401, 3'b100, 32'h00000002, 0};
        vt[14] = '{32'd402, 3'b001, 32'h00000403, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'd0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            do_load(vt[i].addr, vt[i].f3, vt[i].data, vt[i].hold);
        end

        // Reset while both units are waiting on memory
        req_valid  = 1'b1;
        req_addr   = 32'd404;
        req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_valid || b_valid) seen++;
        end
        chk("no_rsp_after_reset", 32'(seen), 32'd0);
        do_load(32'd400, 3'b010, 32'h04030201, 0);

        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
